// File: rtl/mem_io_pkg.sv
// Shared definitions for the RAM preload/dump controller: FSM state encoding
// and the checksum width used when MEMIO_CHECKSUM_EN is defined.
package mem_io_pkg;

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DUMP_RD  = 3'd2,
    ST_DUMP_OUT = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int CSUM_W = 16;

endpackage

// File: rtl/stream_checksum.sv
// Modulo-2^SUM_W running sum of a data stream, with synchronous clear
// (dominant over enable) and per-beat accumulate enable.
module stream_checksum #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16
) (
  input  logic              CLK,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  sum
);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + SUM_W'(data);
    end
  end

endmodule

// File: rtl/mem_preload_dump_ctrl.sv
// Streams an image into RAM after reset (holding the CPU in reset), then dumps
// every location on request. Optional MEMIO_CHECKSUM_EN adds load/dump sums.
module mem_preload_dump_ctrl
  import mem_io_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              dump_start,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic              dump_ready,
  output logic              dump_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy
`ifdef MEMIO_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0] load_sum,
  output logic [CSUM_W-1:0] dump_sum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic              at_last;
  logic              load_beat;
  logic              dump_beat;
  logic              start_ok;

  assign at_last   = (ptr == LAST_ADDR);
  assign load_beat = load_valid & load_ready;
  assign dump_beat = dump_valid & dump_ready;
  assign start_ok  = dump_start & ((state == ST_RUN) | (state == ST_DONE));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_LOAD;
      ptr       <= '0;
      dump_data <= '0;
      dump_addr <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      if (state == ST_DUMP_RD) begin
        dump_data <= mem_rdata;
        dump_addr <= ptr;
      end
    end
  end

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = ptr;
    mem_wdata  = '0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    cpu_hold   = 1'b0;
    busy       = 1'b0;

    case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          if (load_last || at_last) begin
            state_nx = ST_RUN;
            ptr_nx   = '0;
          end else begin
            ptr_nx = ptr + ADDR_W'(1);
          end
        end
      end

      ST_RUN, ST_DONE: begin
        // Present address 0 early so the synchronous RAM has it ready in DUMP_RD.
        mem_addr = '0;
        if (dump_start) begin
          state_nx = ST_DUMP_RD;
          ptr_nx   = '0;
        end
      end

      ST_DUMP_RD: begin
        busy     = 1'b1;
        state_nx = ST_DUMP_OUT;
      end

      ST_DUMP_OUT: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (at_last) begin
            state_nx  = ST_DONE;
            dump_done = 1'b1;
          end else begin
            // Read-ahead: the next address goes out with the handshake.
            ptr_nx   = ptr + ADDR_W'(1);
            mem_addr = ptr_nx;
            state_nx = ST_DUMP_RD;
          end
        end
      end

      default: begin
        state_nx = ST_LOAD;
        ptr_nx   = '0;
      end
    endcase
  end

`ifdef MEMIO_CHECKSUM_EN
  stream_checksum #(
    .DATA_W (DATA_W),
    .SUM_W  (CSUM_W)
  ) u_load_sum (
    .CLK   (CLK),
    .clear (RESET),
    .en    (load_beat),
    .data  (load_data),
    .sum   (load_sum)
  );

  stream_checksum #(
    .DATA_W (DATA_W),
    .SUM_W  (CSUM_W)
  ) u_dump_sum (
    .CLK   (CLK),
    .clear (RESET | start_ok),
    .en    (dump_beat),
    .data  (dump_data),
    .sum   (dump_sum)
  );
`else
  logic unused_ok;
  assign unused_ok = load_beat ^ dump_beat ^ start_ok;
`endif

endmodule

// File: tb/tb_mem_preload_dump_ctrl.sv
// Directed bench for mem_preload_dump_ctrl with a synchronous-read RAM model
// on the memory port and a bench-maintained expected image.
module tb_mem_preload_dump_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              dump_start = 1'b0;
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_ready = 1'b0;
  logic              dump_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_hold;
  logic              busy;
`ifdef MEMIO_CHECKSUM_EN
  logic [15:0]       load_sum;
  logic [15:0]       dump_sum;
`endif

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  mem_preload_dump_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_addr  (dump_addr),
    .dump_ready (dump_ready),
    .dump_done  (dump_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy)
`ifdef MEMIO_CHECKSUM_EN
    ,
    .load_sum   (load_sum),
    .dump_sum   (dump_sum)
`endif
  );

  // Synchronous-read, single-port RAM model: data appears one cycle after address.
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  // One load cycle: drive the beat, then check the write strobe it produces.
  task automatic load_beat(input logic [7:0] d, input logic last, input int exp_addr,
                           input logic exp_accept, input string tag);
    @(negedge CLK);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    #1;
    check({tag, "_ready"}, load_ready, exp_accept);
    check({tag, "_we"}, mem_we, exp_accept);
    if (exp_accept) begin
      check({tag, "_addr"}, mem_addr, exp_addr);
      check({tag, "_wdata"}, mem_wdata, d);
      exp_mem[exp_addr] = d;
    end
  endtask

  task automatic load_idle();
    @(negedge CLK);
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
  endtask

  // Full dump from RUN/DONE. Optionally stalls 5 cycles at stall_at, or
  // asserts RESET when the beat for abort_at is presented.
  task automatic run_dump(input int stall_at, input int abort_at, output int beats);
    int a = 0;
    int cyc = 0;
    int last_hs = -1;
    int stalls = 0;
    @(negedge CLK);
    dump_start = 1'b1;
    dump_ready = 1'b1;
    @(negedge CLK);
    dump_start = 1'b0;
    cyc = 1;
    while (a < DEPTH && cyc < 4 * DEPTH + 40) begin
      dump_ready = !(a == stall_at && stalls < 5);
      #1;
      if (dump_valid) begin
        if (a == abort_at) begin
          RESET      = 1'b1;
          dump_ready = 1'b0;
          break;
        end
        check($sformatf("dump_addr[%0d]", a), dump_addr, a);
        check($sformatf("dump_data[%0d]", a), dump_data, exp_mem[a]);
        if (dump_ready) begin
          check($sformatf("dump_done[%0d]", a), dump_done, (a == DEPTH - 1));
          if (last_hs >= 0)
            check($sformatf("dump_gap[%0d]", a), cyc - last_hs, (a == stall_at) ? 7 : 2);
          last_hs = cyc;
          a++;
        end else begin
          stalls++;
          check($sformatf("stall_done[%0d]", a), dump_done, 0);
        end
      end else begin
        check($sformatf("idle_done[%0d]", a), dump_done, 0);
      end
      @(negedge CLK);
      cyc++;
    end
    dump_ready = 1'b0;
    beats = a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int beats;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 8'(i ^ 8'h5A);
      exp_mem[i] = 8'(i ^ 8'h5A);
    end

    // Reset state
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_ready", load_ready, 1);
    check("rst_busy", busy, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_dump_done", dump_done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_dump_data", dump_data, 0);
    check("rst_dump_addr", dump_addr, 0);

    // Short image terminated by load_last
    load_beat(8'h11, 1'b0, 0, 1'b1, "ld4_0");
    load_beat(8'h22, 1'b0, 1, 1'b1, "ld4_1");
    load_beat(8'h33, 1'b0, 2, 1'b1, "ld4_2");
    load_beat(8'h44, 1'b1, 3, 1'b1, "ld4_3");
    load_idle();
    #1;
    check("ld4_cpu_hold", cpu_hold, 0);
    check("ld4_load_ready", load_ready, 0);
    check("ld4_busy", busy, 0);
    check_ram("ld4_ram");

    // Extra beat in RUN is refused
    load_beat(8'hEE, 1'b0, 0, 1'b0, "run_extra");
    load_idle();
    check_ram("run_extra_ram");

    // Full dump from RUN, ready held high
    run_dump(-1, -1, beats);
    check("dump1_beats", beats, DEPTH);
    #1;
    check("dump1_idle_busy", busy, 0);
    check("dump1_idle_valid", dump_valid, 0);
    check("dump1_idle_cpu_hold", cpu_hold, 0);

    // Repeated dump from DONE, 5-cycle stall at address 7
    run_dump(7, -1, beats);
    check("dump2_beats", beats, DEPTH);

    // Reset, dump_start ignored in LOAD, then 300 beats without load_last
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    dump_start = 1'b1;
    @(negedge CLK);
    dump_start = 1'b0;
    #1;
    check("load_ign_start_ready", load_ready, 1);
    check("load_ign_start_valid", dump_valid, 0);
    for (int i = 0; i < 300; i++)
      load_beat(8'(i * 7 + 3), 1'b0, i, (i < DEPTH), $sformatf("ld300_%0d", i));
    load_idle();
    #1;
    check("ld300_cpu_hold", cpu_hold, 0);
    check("ld300_load_ready", load_ready, 0);
    check_ram("ld300_ram");

    // Reset during dump at address 100, then reload from address 0
    run_dump(-1, 100, beats);
    check("abort_beats", beats, 100);
    @(negedge CLK);
    #1;
    check("abort_cpu_hold", cpu_hold, 1);
    check("abort_dump_valid", dump_valid, 0);
    check("abort_load_ready", load_ready, 1);
    check("abort_ptr", mem_addr, 0);
    RESET = 1'b0;
    load_beat(8'hC1, 1'b0, 0, 1'b1, "reload_0");
    load_beat(8'hC2, 1'b1, 1, 1'b1, "reload_1");
    load_idle();
    #1;
    check("reload_cpu_hold", cpu_hold, 0);
    check_ram("reload_ram");

`ifdef MEMIO_CHECKSUM_EN
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("sum_rst_load", load_sum, 0);
    check("sum_rst_dump", dump_sum, 0);
    for (int i = 0; i < DEPTH; i++)
      load_beat(8'hFF, 1'b0, i, 1'b1, $sformatf("ldff_%0d", i));
    load_idle();
    #1;
    check("sum_load", load_sum, 16'hFF00);
    run_dump(-1, -1, beats);
    check("sum_dump1_beats", beats, DEPTH);
    #1;
    check("sum_dump1", dump_sum, 16'hFF00);
    @(negedge CLK);
    dump_start = 1'b1;
    dump_ready = 1'b1;
    @(negedge CLK);
    dump_start = 1'b0;
    #1;
    check("sum_dump2_clear", dump_sum, 0);
    beats = 0;
    while (busy && beats < 4 * DEPTH) begin
      @(negedge CLK);
      beats++;
    end
    #1;
    check("sum_dump2_finished", busy, 0);
    check("sum_dump2", dump_sum, 16'hFF00);
    dump_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
